// File: rtl/hbridge_pwm_ctrl_pkg.sv
// Shared types and constants for the H-bridge PWM controller and its status display.
// Glyphs are {g,f,e,d,c,b,a} with segments active low.
package hbridge_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [6:0] GLYPH_F    = 7'b0001110;
  localparam logic [6:0] GLYPH_B    = 7'b0000011;
  localparam logic [6:0] GLYPH_E    = 7'b0000110;
  localparam logic [6:0] GLYPH_A    = 7'b0001000;
  localparam logic [6:0] GLYPH_1    = 7'b1111001;
  localparam logic [6:0] GLYPH_G    = 7'b0010000;
  localparam logic [6:0] GLYPH_U    = 7'b1100011;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;

  // Index with the digit number; entry 0 enables the rightmost digit.
  localparam logic [3:0][3:0] DIGIT_EN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic logic [6:0] status_glyph(input logic faulted, input logic idle,
                                              input logic reverse);
    if (faulted)      return GLYPH_E;
    else if (idle)    return GLYPH_DASH;
    else if (reverse) return GLYPH_B;
    else              return GLYPH_F;
  endfunction

endpackage

// File: rtl/hbridge_pwm_ctrl_if.sv
// Board-side signal bundle of the H-bridge controller: switch/comparator inputs,
// gate drives, fault flag and 7-seg display lines.
interface hbridge_pwm_ctrl_if #(
  parameter int DUTY_W = 3
);
  logic [DUTY_W-1:0] duty;
  logic              dir;
  logic              oc_a;
  logic              oc_b;
  logic              fault_clr;
  logic              pwm_fwd;
  logic              pwm_rev;
  logic              fault;
  logic [6:0]        seg;
  logic [3:0]        an;

  modport master (
    output duty, dir, oc_a, oc_b, fault_clr,
    input  pwm_fwd, pwm_rev, fault, seg, an
  );

  modport slave (
    input  duty, dir, oc_a, oc_b, fault_clr,
    output pwm_fwd, pwm_rev, fault, seg, an
  );
endinterface

// File: rtl/hbridge_pwm_ctrl_sseg_mux4.sv
// Four-digit multiplexed 7-seg driver: picks the glyph and active-low digit enable
// for the digit currently selected by the scan counter.
module sseg_mux4
  import hbridge_pwm_ctrl_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [6:0] glyph0,
  input  logic [6:0] glyph1,
  input  logic [6:0] glyph2,
  input  logic [6:0] glyph3,
  output logic [6:0] seg,
  output logic [3:0] an
);

  always_comb begin
    an = DIGIT_EN[sel];
    case (sel)
      2'd0:    seg = glyph0;
      2'd1:    seg = glyph1;
      2'd2:    seg = glyph2;
      default: seg = glyph3;
    endcase
  end

endmodule

// File: rtl/hbridge_pwm_ctrl.sv
// H-bridge PWM controller: free-running PWM counter, period-aligned duty update,
// dead time on reversal, filtered overcurrent latch. Optional SOFT_RAMP_EN enables duty ramping.
//   state    | meaning
//   ST_RUN   | PWM on the bridge side selected by act_dir
//   ST_DEAD  | both gates low for DEADTIME_CYC clocks before (re)driving
//   ST_FAULT | overcurrent latched, both gates low until fault_clr with oc low
module hbridge_pwm_ctrl
  import hbridge_pwm_ctrl_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DUTY_W       = 3,
  parameter int DEADTIME_CYC = 1000,
  parameter int OC_FILT      = 16,
  parameter int RAMP_STEP    = 2 ** (CNT_W - DUTY_W)
) (
  input  logic             clock,
  input  logic             reset,
  hbridge_pwm_ctrl_if.slave bus
);

  localparam int DW   = CNT_W + 1;
  localparam int DT_W = $clog2(DEADTIME_CYC + 1);
  localparam int OC_W = $clog2(OC_FILT + 1);

  if (DEADTIME_CYC < 1 || OC_FILT < 1 || RAMP_STEP < 1 || DUTY_W > CNT_W) begin : g_bad_param
    $error("hbridge_pwm_ctrl: illegal parameter combination");
  end

  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    duty_app, duty_app_nxt, duty_tgt;
  logic             dir_m, dir_s, oc_a_m, oc_a_s, oc_b_m, oc_b_s, oc_hi;
  logic [OC_W-1:0]  oc_cnt;
  logic             oc_trip;
  state_t           state, state_nxt;
  logic             act_dir, act_dir_nxt;
  logic [DT_W-1:0]  dt_cnt, dt_cnt_nxt;
  logic             period_end, pwm_on;
  logic             pwm_fwd_q, pwm_rev_q, pwm_fwd_nxt, pwm_rev_nxt;
  logic [6:0]       glyph0, glyph3, seg_w;
  logic [3:0]       an_w;

  assign oc_hi      = oc_a_s | oc_b_s;
  assign oc_trip    = oc_hi && (oc_cnt >= OC_W'(OC_FILT - 1));
  assign period_end = &cnt;
  assign pwm_on     = ({1'b0, cnt} < duty_app);
  // All-ones code maps to a full period so 100% duty is reachable.
  assign duty_tgt   = (&bus.duty) ? (DW'(1) << CNT_W)
                                  : (DW'(bus.duty) << (CNT_W - DUTY_W));

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_m  <= 1'b0;
      dir_s  <= 1'b0;
      oc_a_m <= 1'b0;
      oc_a_s <= 1'b0;
      oc_b_m <= 1'b0;
      oc_b_s <= 1'b0;
      oc_cnt <= '0;
      cnt    <= '0;
    end else begin
      dir_m  <= bus.dir;
      dir_s  <= dir_m;
      oc_a_m <= bus.oc_a;
      oc_a_s <= oc_a_m;
      oc_b_m <= bus.oc_b;
      oc_b_s <= oc_b_m;
      cnt    <= cnt + 1'b1;
      if (!oc_hi)
        oc_cnt <= '0;
      else if (oc_cnt != OC_W'(OC_FILT))
        oc_cnt <= oc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      act_dir   <= 1'b0;
      dt_cnt    <= '0;
      duty_app  <= '0;
      pwm_fwd_q <= 1'b0;
      pwm_rev_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      act_dir   <= act_dir_nxt;
      dt_cnt    <= dt_cnt_nxt;
      duty_app  <= duty_app_nxt;
      pwm_fwd_q <= pwm_fwd_nxt;
      pwm_rev_q <= pwm_rev_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    act_dir_nxt = act_dir;
    dt_cnt_nxt  = dt_cnt;
    pwm_fwd_nxt = 1'b0;
    pwm_rev_nxt = 1'b0;
    if (oc_trip) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_RUN: begin
          if (dir_s != act_dir) begin
            state_nxt  = ST_DEAD;
            dt_cnt_nxt = '0;
          end
        end
        ST_DEAD: begin
          // A direction that flips back during dead time still waits out the full interval.
          if (dt_cnt == DT_W'(DEADTIME_CYC - 1)) begin
            state_nxt   = ST_RUN;
            act_dir_nxt = dir_s;
          end else begin
            dt_cnt_nxt = dt_cnt + 1'b1;
          end
        end
        ST_FAULT: begin
          if (bus.fault_clr && !oc_hi) begin
            state_nxt  = ST_DEAD;
            dt_cnt_nxt = '0;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    if (state_nxt == ST_RUN) begin
      pwm_fwd_nxt = pwm_on & ~act_dir_nxt;
      pwm_rev_nxt = pwm_on & act_dir_nxt;
    end
  end

`ifdef SOFT_RAMP_EN
  localparam logic [DW:0] STEP_V = (DW + 1)'(RAMP_STEP);
  logic [DW:0]   ramp_up;
  logic [DW-1:0] ramp_val;

  always_comb begin
    ramp_up = {1'b0, duty_app} + STEP_V;
    if (duty_app <= duty_tgt)
      ramp_val = (ramp_up >= {1'b0, duty_tgt}) ? duty_tgt : ramp_up[DW-1:0];
    else
      ramp_val = ({1'b0, duty_app - duty_tgt} <= STEP_V) ? duty_tgt
                                                          : duty_app - STEP_V[DW-1:0];
  end
`endif

  always_comb begin
    duty_app_nxt = duty_app;
    if (state == ST_FAULT && state_nxt == ST_DEAD)
      duty_app_nxt = '0;
`ifdef SOFT_RAMP_EN
    else if (state == ST_RUN && state_nxt == ST_DEAD)
      duty_app_nxt = '0;
    else if (period_end && state == ST_RUN && state_nxt == ST_RUN)
      duty_app_nxt = ramp_val;
`else
    else if (period_end)
      duty_app_nxt = duty_tgt;
`endif
  end

  assign glyph0 = status_glyph(state == ST_FAULT, duty_app == '0, act_dir);
  assign glyph3 = oc_hi ? GLYPH_G : GLYPH_U;

  sseg_mux4 u_sseg (
    .sel    (cnt[CNT_W-1 -: 2]),
    .glyph0 (glyph0),
    .glyph1 (GLYPH_A),
    .glyph2 (GLYPH_1),
    .glyph3 (glyph3),
    .seg    (seg_w),
    .an     (an_w)
  );

  assign bus.pwm_fwd = pwm_fwd_q;
  assign bus.pwm_rev = pwm_rev_q;
  assign bus.fault   = (state == ST_FAULT);
  assign bus.seg     = seg_w;
  assign bus.an      = an_w;

  a_no_shoot_through: assert property (@(posedge clock) disable iff (reset)
    !(pwm_fwd_q && pwm_rev_q));

endmodule

// File: tb/tb_hbridge_pwm_ctrl.sv
// Bench for hbridge_pwm_ctrl: directed scenarios plus randomized duty/dir/overcurrent traffic,
// every clock compared against a cycle-level reference model of the controller's rules.
module tb_hbridge_pwm_ctrl;

  localparam int CNT_W = 6, DUTY_W = 3, DEADTIME_CYC = 4, OC_FILT = 3, RAMP_STEP = 8;
  localparam int PERIOD = 64;
`ifdef SOFT_RAMP_EN
  localparam int SETTLE = 9;
  localparam int T3_LOW = 6;
`else
  localparam int SETTLE = 1;
  localparam int T3_LOW = 4;
`endif
  localparam int M_RUN = 0, M_DEAD = 1, M_FAULT = 2;

  localparam logic [6:0] SEG_F    = ~7'b1110001;
  localparam logic [6:0] SEG_B    = ~7'b1111100;
  localparam logic [6:0] SEG_E    = ~7'b1111001;
  localparam logic [6:0] SEG_A    = ~7'b1110111;
  localparam logic [6:0] SEG_1    = ~7'b0000110;
  localparam logic [6:0] SEG_G    = ~7'b1101111;
  localparam logic [6:0] SEG_U    = ~7'b0011100;
  localparam logic [6:0] SEG_DASH = ~7'b1000000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  hbridge_pwm_ctrl_if #(.DUTY_W(DUTY_W)) bus ();

  hbridge_pwm_ctrl #(
    .CNT_W(CNT_W), .DUTY_W(DUTY_W), .DEADTIME_CYC(DEADTIME_CYC),
    .OC_FILT(OC_FILT), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  int       m_cnt, m_duty_app, m_mode, m_dead_left, m_oc_run;
  bit       m_act_dir, m_fwd, m_rev;
  bit [1:0] m_dir_q, m_oc_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: advances one clock from the sampled inputs.
  task automatic model_edge();
    int  tgt, prev_mode;
    bit  oc_hi, dir_s, pwm_on;
    if (reset) begin
      m_cnt = 0; m_duty_app = 0; m_mode = M_RUN; m_act_dir = 0;
      m_fwd = 0; m_rev = 0; m_dead_left = 0; m_oc_run = 0;
      m_dir_q = 2'b00; m_oc_q = 2'b00;
      return;
    end
    dir_s     = m_dir_q[1];
    oc_hi     = m_oc_q[1];
    pwm_on    = (m_cnt < m_duty_app);
    tgt       = (int'(bus.duty) == 7) ? PERIOD : int'(bus.duty) * (PERIOD / 8);
    prev_mode = m_mode;
    m_oc_run  = oc_hi ? m_oc_run + 1 : 0;
    if (oc_hi && m_oc_run >= OC_FILT) begin
      m_mode = M_FAULT;
    end else if (m_mode == M_RUN) begin
      if (dir_s != m_act_dir) begin m_mode = M_DEAD; m_dead_left = DEADTIME_CYC; end
    end else if (m_mode == M_DEAD) begin
      m_dead_left--;
      if (m_dead_left == 0) begin m_mode = M_RUN; m_act_dir = dir_s; end
    end else if (bus.fault_clr && !oc_hi) begin
      m_mode = M_DEAD; m_dead_left = DEADTIME_CYC;
    end
    if (prev_mode == M_FAULT && m_mode == M_DEAD)
      m_duty_app = 0;
`ifdef SOFT_RAMP_EN
    else if (prev_mode == M_RUN && m_mode == M_DEAD)
      m_duty_app = 0;
    else if (m_cnt == PERIOD - 1 && prev_mode == M_RUN && m_mode == M_RUN) begin
      if (m_duty_app < tgt) m_duty_app = (m_duty_app + RAMP_STEP > tgt) ? tgt : m_duty_app + RAMP_STEP;
      else                  m_duty_app = (m_duty_app - RAMP_STEP < tgt) ? tgt : m_duty_app - RAMP_STEP;
    end
`else
    else if (m_cnt == PERIOD - 1)
      m_duty_app = tgt;
`endif
    m_fwd   = (m_mode == M_RUN) && pwm_on && !m_act_dir;
    m_rev   = (m_mode == M_RUN) && pwm_on && m_act_dir;
    m_cnt   = (m_cnt + 1) % PERIOD;
    m_dir_q = {m_dir_q[0], bus.dir};
    m_oc_q  = {m_oc_q[0], bus.oc_a | bus.oc_b};
  endtask

  function automatic logic [6:0] exp_seg();
    case (m_cnt / 16)
      0: begin
        if (m_mode == M_FAULT)    return SEG_E;
        else if (m_duty_app == 0) return SEG_DASH;
        else if (m_act_dir)       return SEG_B;
        else                      return SEG_F;
      end
      1:       return SEG_A;
      2:       return SEG_1;
      default: return m_oc_q[1] ? SEG_G : SEG_U;
    endcase
  endfunction

  task automatic step();
    logic [3:0] an_exp;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    an_exp = 4'hF & ~(4'd1 << (m_cnt / 16));
    check("pwm_fwd", bus.pwm_fwd, m_fwd);
    check("pwm_rev", bus.pwm_rev, m_rev);
    check("fault", bus.fault, m_mode == M_FAULT);
    check("seg", bus.seg, exp_seg());
    check("an", bus.an, an_exp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic count_period(output int fwd_hi, output int rev_hi);
    fwd_hi = 0;
    rev_hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      fwd_hi += int'(bus.pwm_fwd);
      rev_hi += int'(bus.pwm_rev);
    end
  endtask

  initial begin
    int fh, rh, low;
    bus.duty = '0; bus.dir = 1'b0; bus.oc_a = 1'b0; bus.oc_b = 1'b0; bus.fault_clr = 1'b0;
    reset = 1'b1;
    run(3);
    check("rst_an", bus.an, 4'b1110);
    check("rst_outs", {bus.pwm_fwd, bus.pwm_rev, bus.fault}, 3'b000);
    reset = 1'b0;

    // half duty forward
    bus.duty = 3'd4;
    run((SETTLE + 1) * PERIOD);
    count_period(fh, rh);
    check("t1_fwd_hi", fh, 32);
    check("t1_rev_hi", rh, 0);

    // full and zero duty
    bus.duty = 3'd7;
    run(SETTLE * PERIOD);
    count_period(fh, rh);
    check("t2_full_hi", fh, PERIOD);
    bus.duty = 3'd0;
    run(SETTLE * PERIOD);
    count_period(fh, rh);
    check("t2_zero_hi", fh + rh, 0);

    // reversal mid-period with dead time
    bus.duty = 3'd4;
    run((SETTLE + 1) * PERIOD);
    for (int i = 0; i < PERIOD && m_cnt != 4; i++) step();
    bus.dir = 1'b1;
    low = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (!bus.pwm_fwd && !bus.pwm_rev) low++;
    end
    check("t3_dead_len", low, T3_LOW);
    run(SETTLE * PERIOD);
    count_period(fh, rh);
    check("t3_rev_hi", rh, 32);
    check("t3_fwd_hi", fh, 0);

    // overcurrent filter, latch and clear
    bus.oc_a = 1'b1; run(2); bus.oc_a = 1'b0;
    run(6);
    check("t4_no_trip", bus.fault, 1'b0);
    bus.oc_a = 1'b1; run(3); bus.oc_a = 1'b0;
    run(4);
    check("t4_trip", bus.fault, 1'b1);
    check("t4_outs_off", {bus.pwm_fwd, bus.pwm_rev}, 2'b00);
    bus.oc_b = 1'b1; run(4);
    bus.fault_clr = 1'b1; step(); bus.fault_clr = 1'b0;
    run(2);
    check("t4_clr_ignored", bus.fault, 1'b1);
    bus.oc_b = 1'b0; run(4);
    bus.fault_clr = 1'b1; step(); bus.fault_clr = 1'b0;
    check("t4_clr", bus.fault, 1'b0);
    run((SETTLE + 1) * PERIOD);
    count_period(fh, rh);
    check("t4_resume_hi", rh, 32);

`ifdef SOFT_RAMP_EN
    bus.duty = 3'd0;
    run(SETTLE * PERIOD);
    bus.duty = 3'd4;
    for (int i = 0; i < PERIOD && m_cnt != 0; i++) step();
    for (int k = 1; k <= 4; k++) begin
      count_period(fh, rh);
      check("t5_ramp_up", fh + rh, 8 * k);
    end
    bus.duty = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      count_period(fh, rh);
      check("t5_ramp_dn", fh + rh, 8 * k);
    end
`endif

    // reset during dead time
    bus.dir = 1'b0;
    run(4);
    check("t6_in_dead", m_mode, M_DEAD);
    reset = 1'b1;
    step();
    check("t6_an", bus.an, 4'b1110);
    check("t6_outs", {bus.pwm_fwd, bus.pwm_rev, bus.fault}, 3'b000);
    reset = 1'b0;

    // randomized traffic
    for (int r = 0; r < 40; r++) begin
      bus.duty = 3'($urandom_range(0, 7));
      bus.dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) bus.oc_a = 1'b1; else bus.oc_b = 1'b1;
        run($urandom_range(1, 5));
        bus.oc_a = 1'b0; bus.oc_b = 1'b0;
      end
      if (m_mode == M_FAULT && $urandom_range(0, 2) != 0) begin
        run($urandom_range(0, 3));
        bus.fault_clr = 1'b1; step(); bus.fault_clr = 1'b0;
      end
      run($urandom_range(10, 80));
    end
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
